// File: rtl/count_bcd.sv
`default_nettype none
// ============================================================================
// Module   : count_bcd
// Purpose  : Sequential binary-to-BCD converter (shift-and-add-3). Converts the
//            WIDTH-bit count of an upstream counter into DIGITS packed BCD
//            digits in WIDTH clock cycles, then pulses done for one cycle.
//            Optional macro COUNT_BCD_SEVSEG_EN adds an active-low seven-segment
//            decode of the result on port seg ({g,f,e,d,c,b,a} per digit).
// Revision : 1.0 - initial release
// ============================================================================
module count_bcd #(
   parameter int WIDTH  = 6,
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
`ifdef COUNT_BCD_SEVSEG_EN
   ,
   output logic [7*DIGITS-1:0]   seg
`endif
);

   // Counter must be able to hold the value WIDTH.
   localparam int c_CW = $clog2(WIDTH + 1);

   function automatic longint unsigned f_pow10(input int n);
      longint unsigned p;
      p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   // Refuse to build when the largest binary input cannot be represented.
   if (f_pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_params
      $error("count_bcd: 10**DIGITS must exceed 2**WIDTH-1");
   end

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CONVERT = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic                      w_accept;
   logic                      w_last;
   logic [WIDTH-1:0]          r_shift;
   logic [4*DIGITS-1:0]       r_scratch;
   logic [c_CW-1:0]           r_cnt;
   logic [4*DIGITS-1:0]       r_bcd;
   logic [4*DIGITS-1:0]       w_adj;
   logic [4*DIGITS+WIDTH-1:0] w_cat;

   // Add-3 correction on every scratch digit that would overflow when doubled.
   genvar gi;
   for (gi = 0; gi < DIGITS; gi++) begin : g_adjust
      assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5)
                              ? r_scratch[4*gi +: 4] + 4'd3
                              : r_scratch[4*gi +: 4];
   end

   // Corrected scratch and remaining binary bits shift left as one register.
   assign w_cat = {w_adj, r_shift} << 1;

   // State register; reset aborts any conversion immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state decode plus status outputs; DONE always lasts a single cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            done = (r_state == S_DONE);
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_CONVERT;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_CONVERT: begin
            busy = 1'b1;
            if (r_cnt == c_CW'(1)) begin
               w_last      = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath: capture on accept, shift during conversion, publish on last step.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shift   <= '0;
         r_scratch <= '0;
         r_cnt     <= '0;
         r_bcd     <= '0;
      end else if (w_accept) begin
         r_shift   <= bin;
         r_scratch <= '0;
         r_cnt     <= c_CW'(WIDTH);
      end else if (r_state == S_CONVERT) begin
         r_scratch <= w_cat[4*DIGITS+WIDTH-1:WIDTH];
         r_shift   <= w_cat[WIDTH-1:0];
         r_cnt     <= r_cnt - c_CW'(1);
         if (w_last) r_bcd <= w_cat[4*DIGITS+WIDTH-1:WIDTH];
      end
   end

   assign bcd = r_bcd;

`ifdef COUNT_BCD_SEVSEG_EN
   // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal codes blank.
   function automatic logic [6:0] f_seg(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   for (gi = 0; gi < DIGITS; gi++) begin : g_seg
      assign seg[7*gi +: 7] = f_seg(r_bcd[4*gi +: 4]);
   end
`endif

endmodule
`default_nettype wire

// File: doc/count_bcd.md
COUNT_BCD -- requirements
Module: count_bcd

Interface
REQ-001 Parameter WIDTH, default 6: bit width of the binary input, matching the upstream counter's count width.
REQ-002 Parameter DIGITS, default 2: number of BCD output digits; elaboration SHALL fail unless 10^DIGITS > 2^WIDTH - 1.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 reset  input  1: asynchronous, active-low reset.
REQ-005 start  input  1: conversion request, sampled on the rising clk edge.
REQ-006 bin  input  WIDTH: binary value to convert (the counter's count output); sampled only when start is accepted.
REQ-007 busy  output  1: high while a conversion is in progress.
REQ-008 done  output  1: one-cycle pulse when a conversion result is loaded.
REQ-009 bcd  output  4*DIGITS: packed BCD result, digit 0 (units) in bits [3:0].

Function
REQ-010 FSM states SHALL be IDLE, CONVERT and DONE.
REQ-011 In IDLE or DONE, start=1 SHALL capture bin into an internal shift register, clear the scratch BCD register, load the iteration counter with WIDTH and move to CONVERT.
REQ-012 In IDLE or DONE, start=0 SHALL move to IDLE (DONE always lasts exactly one cycle).
REQ-013 Each CONVERT cycle SHALL add 3 to every scratch digit >= 5, then shift {scratch, shift register} left by one bit and decrement the iteration counter.
REQ-014 On the CONVERT cycle where the iteration counter reaches 0, the updated scratch value SHALL be loaded into bcd and the FSM SHALL move to DONE.
REQ-015 Latency SHALL be exactly WIDTH clock edges from the edge that accepts start to the edge that loads bcd; done is high for the following cycle.
REQ-016 busy SHALL be 1 in CONVERT only; done SHALL be 1 in DONE only; busy and done are never high together.
REQ-017 start while in CONVERT SHALL be ignored; changes to bin during CONVERT SHALL NOT affect the result.
REQ-018 bcd SHALL hold its last result until the next conversion completes, including through a new conversion in progress.
REQ-019 bin=0 SHALL produce bcd=0, and bin=2^WIDTH-1 SHALL produce its exact decimal value; there is no overflow condition given REQ-002.
REQ-020 start held high continuously SHALL produce back-to-back conversions, each taking WIDTH+1 cycles including the DONE cycle.

Reset
REQ-021 reset=0 SHALL immediately, without waiting for clk, force the FSM to IDLE and busy=0, done=0 and bcd=0, and clear the shift, scratch and iteration registers.
REQ-022 Reset asserted during CONVERT SHALL abort the conversion; no done pulse follows, and bcd stays 0 until a new conversion completes.
REQ-023 On the first rising edge after reset is released, start SHALL be honoured normally.

Configuration
REQ-024 With macro COUNT_BCD_SEVSEG_EN defined, output seg (7*DIGITS, active-low, per digit bits {g,f,e,d,c,b,a}) SHALL be decoded combinationally from bcd; digit values outside 0-9 SHALL show all segments off.
REQ-025 Without COUNT_BCD_SEVSEG_EN, port seg and its decode logic SHALL be absent, and all other behaviour is unchanged.

Verification
REQ-026 Reset: reset=0 mid-CONVERT -> busy=0, done=0, bcd=0 before the next clk edge; no done pulse afterwards.
REQ-027 WIDTH=6: start with bin=63 -> busy high for 6 cycles, then done=1 for 1 cycle with bcd=8'h63.
REQ-028 WIDTH=6: bin=0, then bin=9, then bin=10 -> bcd=8'h00, 8'h09, 8'h10 respectively.
REQ-029 WIDTH=4, DIGITS=2: upstream counter driving bin with start pulsed per count over 0..15 -> bcd follows 8'h00..8'h15, wrapping to 8'h00 when the counter wraps.
REQ-030 Start pulsed during CONVERT with a different bin -> ignored; result equals the originally captured value; start held high -> done every 7th cycle (WIDTH=6).
REQ-031 With COUNT_BCD_SEVSEG_EN and bcd=8'h10 -> seg=14'b1111001_1000000.
